// File: rtl/spi_tx_pkg.sv
// Shared definitions for the SPI frame initiators: FSM state codes,
// mode-0 line levels and default timing parameters.
package spi_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LEAD  = 3'd1;
    localparam state_t ST_HIGH  = 3'd2;
    localparam state_t ST_LOW   = 3'd3;
    localparam state_t ST_TRAIL = 3'd4;
    localparam state_t ST_GAP   = 3'd5;

    // Mode 0: SCLK idles low, chip select is active-low.
    localparam logic SCLK_IDLE    = 1'b0;
    localparam logic CSB_INACTIVE = 1'b1;

    localparam int DEFAULT_HALF_DIV   = 2;
    localparam int DEFAULT_GAP_CYCLES = 4;

endpackage

// File: rtl/spi_half_tick.sv
// Loadable down-counter: o_tick is high for one cycle every (i_load+1) cycles,
// and the period restarts from i_load whenever i_restart is asserted.
module spi_half_tick #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_restart,
    input  logic [CNT_W-1:0] i_load,
    output logic             o_tick
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (i_restart || (count_q == '0)) begin
            count_d = i_load;
        end else begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            count_q <= count_d;
        end
    end

    assign o_tick = (count_q == '0);

endmodule

// File: rtl/spi_frame_tx.sv
// SPI mode-0 frame initiator: serialises a right-aligned payload MSB-first
// with fully registered CSB/SCLK/MOSI and an enforced CSB-high gap.
module spi_frame_tx
    import spi_tx_pkg::*;
#(
    parameter int MAX_BITS   = 48,
    parameter int HALF_DIV   = DEFAULT_HALF_DIV,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int LEN_W      = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [LEN_W-1:0]    i_len,
    input  logic [MAX_BITS-1:0] i_data,
    output logic                o_csb,
    output logic                o_sclk,
    output logic                o_mosi,
    output logic                o_busy,
    output logic                o_done
);

    localparam int TICK_MAX = (HALF_DIV > GAP_CYCLES) ? HALF_DIV : GAP_CYCLES;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    localparam logic [LEN_W-1:0]  MAX_LEN    = LEN_W'(MAX_BITS);
    localparam logic [LEN_W-1:0]  LAST_BIT   = LEN_W'(1);
    localparam logic [TICK_W-1:0] PHASE_LOAD = TICK_W'(HALF_DIV - 1);
    localparam logic [TICK_W-1:0] GAP_LOAD   = TICK_W'(GAP_CYCLES - 1);

    state_t              state_q, state_d;
    logic [MAX_BITS-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]    bits_q, bits_d;
    logic                csb_q, csb_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic                tick;
    logic                restart;
    logic [TICK_W-1:0]   tick_load;
    logic [LEN_W-1:0]    len_clamped;
    logic [MAX_BITS-1:0] data_aligned;

    assign accept       = i_valid & ready_q;
    assign len_clamped  = (i_len > MAX_LEN) ? MAX_LEN : i_len;
    assign data_aligned = i_data << (MAX_LEN - len_clamped);

    // Every phase starts with a fresh count, so each lasts exactly its load+1 cycles.
    assign restart   = (state_d != state_q);
    assign tick_load = (state_d == ST_GAP) ? GAP_LOAD : PHASE_LOAD;

    spi_half_tick #(
        .CNT_W (TICK_W)
    ) u_half_tick (
        .clk       (clk),
        .reset     (reset),
        .i_restart (restart),
        .i_load    (tick_load),
        .o_tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bits_d  = bits_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = data_aligned;
                    bits_d  = len_clamped;
                    if (len_clamped == '0) begin
                        state_d = ST_GAP;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LEAD;
                        mosi_d  = data_aligned[MAX_BITS-1];
                    end
                end
            end

            ST_LEAD: begin
                if (tick) state_d = ST_HIGH;
            end

            ST_HIGH: begin
                if (tick) begin
                    if (bits_q == LAST_BIT) begin
                        state_d = ST_TRAIL;
                    end else begin
                        // Next bit is presented on the falling edge, a full half-period before the rise.
                        state_d = ST_LOW;
                        shift_d = shift_q << 1;
                        bits_d  = bits_q - 1'b1;
                        mosi_d  = shift_q[MAX_BITS-2];
                    end
                end
            end

            ST_LOW: begin
                if (tick) state_d = ST_HIGH;
            end

            ST_TRAIL: begin
                if (tick) begin
                    state_d = ST_GAP;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                end
            end

            ST_GAP: begin
                if (tick) state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        csb_d   = ((state_d == ST_IDLE) || (state_d == ST_GAP)) ? CSB_INACTIVE : ~CSB_INACTIVE;
        sclk_d  = (state_d == ST_HIGH) ? ~SCLK_IDLE : SCLK_IDLE;
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bits_q  <= '0;
            csb_q   <= CSB_INACTIVE;
            sclk_q  <= SCLK_IDLE;
            mosi_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_csb   = csb_q;
    assign o_sclk  = sclk_q;
    assign o_mosi  = mosi_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule
